// File: rtl/primogen_seek_if.sv
// Handshake bundle for the seekable prime generator: requester drives go/load/from,
// generator returns ready/error/res.
interface primogen_seek_if #(
   parameter int WIDTH_LOG = 4
);
   localparam int WIDTH = 1 << WIDTH_LOG;

   logic             go;
   logic             load;
   logic [WIDTH-1:0] from;
   logic             ready;
   logic             error;
   logic [WIDTH-1:0] res;

   modport master (output go, load, from, input ready, error, res);
   modport slave  (input go, load, from, output ready, error, res);
endinterface

// File: rtl/primogen_seek.sv
// Seekable prime generator: returns the smallest prime strictly above a base value
// using trial division by odd divisors through a bit-serial restoring mod unit.
//
// state   | meaning
// S_READY | idle, res valid, go accepted
// S_ERROR | idle, last search overflowed, res holds pre-search value
// S_CHECK | one cycle: accept p if div^2 > p, else start a division
// S_DIV   | WIDTH cycles computing p mod div, one quotient bit per cycle
module primogen_seek #(
   parameter int WIDTH_LOG = 4
) (
   input  logic            clk,
   input  logic            rst,
   primogen_seek_if.slave  bus
);
   localparam int WIDTH = 1 << WIDTH_LOG;

   typedef enum logic [1:0] {S_READY, S_ERROR, S_CHECK, S_DIV} state_t;

   state_t               state_q;
   logic [WIDTH-1:0]     p_q;
   logic [WIDTH-1:0]     div_q;
   logic [WIDTH+1:0]     dsq_q;
   logic [WIDTH-1:0]     rem_q;
   logic [WIDTH-1:0]     sh_q;
   logic [WIDTH_LOG-1:0] cnt_q;
   logic [WIDTH-1:0]     res_q;
   logic                 ready_q;
   logic                 error_q;

   logic [WIDTH-1:0]     base_d;
   logic [WIDTH:0]       cand_d;
   logic [WIDTH:0]       rem_sh_d;
   logic [WIDTH-1:0]     rem_d;
   logic [WIDTH:0]       p_inc_d;
   logic [WIDTH+1:0]     dsq_inc_d;

   always_comb begin
      base_d = bus.load ? bus.from : res_q;
      if (base_d < WIDTH'(2))
         cand_d = (WIDTH+1)'(2);
      else if (base_d == WIDTH'(2))
         cand_d = (WIDTH+1)'(3);
      else if (base_d[0])
         cand_d = {1'b0, base_d} + (WIDTH+1)'(2);
      else
         cand_d = {1'b0, base_d} + (WIDTH+1)'(1);

      // rem < div always holds, so one conditional subtract restores the remainder
      rem_sh_d = {rem_q, sh_q[WIDTH-1]};
      if (rem_sh_d >= {1'b0, div_q})
         rem_d = WIDTH'(rem_sh_d - {1'b0, div_q});
      else
         rem_d = rem_sh_d[WIDTH-1:0];

      p_inc_d   = {1'b0, p_q} + (WIDTH+1)'(2);
      dsq_inc_d = dsq_q + {div_q, 2'b00} + (WIDTH+2)'(4);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_READY;
         p_q     <= '0;
         div_q   <= '0;
         dsq_q   <= '0;
         rem_q   <= '0;
         sh_q    <= '0;
         cnt_q   <= '0;
         res_q   <= WIDTH'(1);
         ready_q <= 1'b1;
         error_q <= 1'b0;
      end else begin
         case (state_q)
            S_READY, S_ERROR: begin
               if (bus.go) begin
                  if (cand_d[WIDTH]) begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end else begin
                     p_q     <= cand_d[WIDTH-1:0];
                     div_q   <= WIDTH'(3);
                     dsq_q   <= (WIDTH+2)'(9);
                     state_q <= S_CHECK;
                     ready_q <= 1'b0;
                     error_q <= 1'b0;
                  end
               end
            end
            S_CHECK: begin
               if (p_q == WIDTH'(2) || dsq_q > {2'b00, p_q}) begin
                  res_q   <= p_q;
                  state_q <= S_READY;
                  ready_q <= 1'b1;
               end else begin
                  rem_q   <= '0;
                  sh_q    <= p_q;
                  cnt_q   <= WIDTH_LOG'(WIDTH - 1);
                  state_q <= S_DIV;
               end
            end
            S_DIV: begin
               rem_q <= rem_d;
               sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) begin
                  if (rem_d == '0) begin
                     if (p_inc_d[WIDTH]) begin
                        state_q <= S_ERROR;
                        ready_q <= 1'b1;
                        error_q <= 1'b1;
                     end else begin
                        p_q     <= p_inc_d[WIDTH-1:0];
                        div_q   <= WIDTH'(3);
                        dsq_q   <= (WIDTH+2)'(9);
                        state_q <= S_CHECK;
                     end
                  end else begin
                     div_q   <= div_q + WIDTH'(2);
                     dsq_q   <= dsq_inc_d;
                     state_q <= S_CHECK;
                  end
               end
            end
            default: state_q <= S_READY;
         endcase
      end
   end

   assign bus.ready = ready_q;
   assign bus.error = error_q;
   assign bus.res   = res_q;
endmodule

// File: tb/tb_primogen_seek.sv
// Scoreboard bench for primogen_seek: 16-bit and 8-bit instances, directed vectors,
// monitors pop expected {res, error, busy cycles} at each search completion.
module tb_primogen_seek;
   logic clk;
   logic rst;

   primogen_seek_if #(.WIDTH_LOG(4)) b16 ();
   primogen_seek_if #(.WIDTH_LOG(3)) b8 ();

   primogen_seek #(.WIDTH_LOG(4)) u16 (.clk(clk), .rst(rst), .bus(b16));
   primogen_seek #(.WIDTH_LOG(3)) u8  (.clk(clk), .rst(rst), .bus(b8));

   typedef struct {
      int res;
      int err;
      int lat;
   } exp_t;

   exp_t q16[$];
   exp_t q8[$];

   int n_chk  = 0;
   int n_fail = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Monitors: a completion is an idle sample following a busy sample or an accepted go.
   bit m16_pr = 1'b1, m16_pg = 1'b0;
   int m16_lat = 0;
   always @(negedge clk) begin
      if (rst) begin
         m16_pr = 1'b1; m16_pg = 1'b0; m16_lat = 0;
      end else begin
         if ((!m16_pr || m16_pg) && b16.ready) begin
            if (q16.size() == 0) begin
               check("w16_unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = q16.pop_front();
               check("w16_res", int'(b16.res), e.res);
               check("w16_error", int'(b16.error), e.err);
               if (e.lat >= 0) check("w16_latency", m16_lat, e.lat);
            end
            m16_lat = 0;
         end else if (!b16.ready) begin
            m16_lat++;
         end
         m16_pr = b16.ready;
         m16_pg = b16.go;
      end
   end

   bit m8_pr = 1'b1, m8_pg = 1'b0;
   int m8_lat = 0;
   always @(negedge clk) begin
      if (rst) begin
         m8_pr = 1'b1; m8_pg = 1'b0; m8_lat = 0;
      end else begin
         if ((!m8_pr || m8_pg) && b8.ready) begin
            if (q8.size() == 0) begin
               check("w8_unexpected_done", 1, 0);
            end else begin
               exp_t e;
               e = q8.pop_front();
               check("w8_res", int'(b8.res), e.res);
               check("w8_error", int'(b8.error), e.err);
               if (e.lat >= 0) check("w8_latency", m8_lat, e.lat);
            end
            m8_lat = 0;
         end else if (!b8.ready) begin
            m8_lat++;
         end
         m8_pr = b8.ready;
         m8_pg = b8.go;
      end
   end

   task automatic wait_idle(input bit sel);
      int n = 0;
      while (!(sel ? b8.ready : b16.ready) && n < 3000) begin
         @(posedge clk);
         #2;
         n++;
      end
      if (n >= 3000) begin
         n_chk++;
         n_fail++;
         $display("FAIL wait_idle: ready still 0 after %0d cycles, expected 1", n);
      end
   endtask

   task automatic issue(input bit sel, input bit ld, input int frm,
                        input int r, input int e, input int lat);
      exp_t x;
      wait_idle(sel);
      x.res = r; x.err = e; x.lat = lat;
      if (sel) begin
         q8.push_back(x);
         b8.load = ld; b8.from = 8'(frm); b8.go = 1'b1;
      end else begin
         q16.push_back(x);
         b16.load = ld; b16.from = 16'(frm); b16.go = 1'b1;
      end
      @(posedge clk);
      #2;
      b8.go  = 1'b0;
      b16.go = 1'b0;
      wait_idle(sel);
   endtask

   initial begin
      exp_t x;
      rst = 1'b1;
      b16.go = 1'b0; b16.load = 1'b0; b16.from = '0;
      b8.go  = 1'b0; b8.load  = 1'b0; b8.from  = '0;
      #23 rst = 1'b0;
      @(posedge clk);
      #2;
      check("reset_ready", int'(b16.ready), 1);
      check("reset_error", int'(b16.error), 0);
      check("reset_res", int'(b16.res), 1);

      // incremental run from reset
      issue(0, 0, 0, 2, 0, 1);
      issue(0, 0, 0, 3, 0, 1);
      issue(0, 0, 0, 5, 0, 1);
      issue(0, 0, 0, 7, 0, 1);
      // 65535 divisible by 3, next candidate wraps
      issue(0, 1, 65534, 7, 1, 17);
      // first candidate itself overflows
      issue(0, 1, 65535, 7, 1, 0);
      issue(0, 1, 0, 2, 0, 1);
      issue(0, 1, 13, 17, 0, 35);
      issue(0, 0, 0, 19, 0, 18);
      issue(0, 1, 100, 101, 0, 69);
      issue(0, 1, 1, 2, 0, 1);
      issue(0, 1, 2, 3, 0, 1);
      // 9 must be rejected: dsq == p is not enough
      issue(0, 1, 7, 11, 0, 35);

      // go held high; load/from churn while busy is ignored; restart from new res
      wait_idle(0);
      x.res = 13; x.err = 0; x.lat = 18; q16.push_back(x);
      x.res = 17; x.err = 0; x.lat = 35; q16.push_back(x);
      b16.load = 1'b0; b16.go = 1'b1;
      @(posedge clk);
      #2;
      repeat (8) begin
         b16.load = ~b16.load;
         b16.from = 16'($urandom);
         @(posedge clk);
         #2;
      end
      b16.load = 1'b0;
      wait_idle(0);
      @(posedge clk);
      #2;
      b16.go = 1'b0;
      wait_idle(0);

      // asynchronous reset during a division
      b16.load = 1'b1; b16.from = 16'd100; b16.go = 1'b1;
      @(posedge clk);
      #2;
      b16.go = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("busy_before_rst", int'(b16.ready), 0);
      #2 rst = 1'b1;
      #1;
      check("async_rst_ready", int'(b16.ready), 1);
      check("async_rst_error", int'(b16.error), 0);
      check("async_rst_res", int'(b16.res), 1);
      #4 rst = 1'b0;
      @(posedge clk);
      #2;
      issue(0, 0, 0, 2, 0, 1);

      // 8-bit instance
      issue(1, 1, 24, 29, 0, 46);
      issue(1, 1, 251, 29, 1, 54);
      issue(1, 1, 255, 29, 1, 0);
      issue(1, 1, 0, 2, 0, 1);

      repeat (3) @(posedge clk);
      check("q16_drained", q16.size(), 0);
      check("q8_drained", q8.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
